// File: rtl/tc_sched_pkg.sv
// Shared state encoding and index-width helper for the tensor core scheduler.
package tc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FETCH,
    ST_DONE,
    ST_COMPUTE,
    ST_WB,
    ST_DRAIN
  } sched_state_t;

  // Width of an index over n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_core_scheduler_if.sv
// Request, core-handshake and result signals of the tensor core scheduler.
// master: scheduler side; slave: issue logic / tensor core side.
interface tensor_core_scheduler_if
  import tc_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int FETCH_BEATS  = 8,
  parameter int RESULT_BEATS = 8
);
  localparam int unsigned FBW = idx_w(FETCH_BEATS);
  localparam int unsigned RBW = idx_w(RESULT_BEATS);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tc_idle;
  logic                         tc_fetch;
  logic                         tc_compute;
  logic                         tc_write_back;
  logic                         tc_start;
  logic                         tc_fetch_done;
  logic                         fetch_rd_en;
  logic [FBW-1:0]               fetch_beat;
  logic                         res_valid;
  logic [RBW-1:0]               res_beat;
  logic                         res_last;
  logic [TAG_WIDTH-1:0]         res_tag;
  logic                         busy;
  logic                         err_timeout;

  modport master (
    input  req_valid, req_tag, tc_idle, tc_fetch, tc_compute, tc_write_back,
    output req_ready, tc_start, tc_fetch_done, fetch_rd_en, fetch_beat,
           res_valid, res_beat, res_last, res_tag, busy, err_timeout
  );

  modport slave (
    output req_valid, req_tag, tc_idle, tc_fetch, tc_compute, tc_write_back,
    input  req_ready, tc_start, tc_fetch_done, fetch_rd_en, fetch_beat,
           res_valid, res_beat, res_last, res_tag, busy, err_timeout
  );

endinterface

// File: rtl/tc_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module tc_rr_arbiter
  import tc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);
  localparam int unsigned PW = idx_w(NUM_REQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (32'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Job sequencer for the tensor core: grant, start, fetch, compute, write-back, drain.
// Optional watchdog enabled by defining TC_SCHED_TIMEOUT_EN.
module tensor_core_scheduler
  import tc_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int FETCH_BEATS    = 8,
  parameter int RESULT_BEATS   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  tensor_core_scheduler_if.master  bus
);
  localparam int unsigned FBW = idx_w(FETCH_BEATS);
  localparam int unsigned RBW = idx_w(RESULT_BEATS);
  localparam logic [FBW-1:0] FETCH_LAST = FBW'(FETCH_BEATS - 1);
  localparam logic [RBW-1:0] RES_LAST   = RBW'(RESULT_BEATS - 1);

  sched_state_t         state_q, state_d;
  logic [FBW-1:0]       fb_q, fb_d;
  logic [RBW-1:0]       rb_q, rb_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, tag_sel;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_en;
  logic                 accept;
  logic                 res_valid;
  logic                 timeout;
  logic                 unused_status;

  assign unused_status = bus.tc_compute;

  // Grants are only offered from IDLE with the core idle, and never during reset.
  assign grant_en      = (state_q == ST_IDLE) && bus.tc_idle && !rst;
  assign bus.req_ready = grant_en ? grant : '0;
  assign accept        = |bus.req_ready;

  tc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    tag_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) tag_sel = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

`ifdef TC_SCHED_TIMEOUT_EN
  localparam int unsigned WDW = idx_w(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_q;
  logic           wd_active;
  logic           err_q;

  assign wd_active = (state_q == ST_FETCH) || (state_q == ST_COMPUTE) ||
                     (state_q == ST_WB)    || (state_q == ST_DRAIN);
  assign timeout   = wd_active && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (!wd_active || (state_d != state_q)) wd_q <= '0;
      else                                    wd_q <= wd_q + WDW'(1);
    end
  end

  assign bus.err_timeout = err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign timeout         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    fb_d      = fb_q;
    rb_d      = rb_q;
    tag_d     = tag_q;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tag_d   = tag_sel;
          state_d = ST_START;
        end
      end
      ST_START: begin
        fb_d    = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.tc_fetch) begin
          if (fb_q == FETCH_LAST) begin
            fb_d    = '0;
            state_d = ST_DONE;
          end else begin
            fb_d = fb_q + FBW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_COMPUTE;
      // The first write-back cycle seen in COMPUTE is already result beat 0.
      ST_COMPUTE, ST_WB: begin
        if (bus.tc_write_back) begin
          res_valid = 1'b1;
          if (rb_q == RES_LAST) begin
            rb_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            rb_d    = rb_q + RBW'(1);
            state_d = ST_WB;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.tc_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      res_valid = 1'b0;
      fb_d      = '0;
      rb_d      = '0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fb_q    <= '0;
      rb_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      rb_q    <= rb_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.tc_start      = (state_q == ST_START);
  assign bus.tc_fetch_done = (state_q == ST_DONE);
  assign bus.fetch_rd_en   = (state_q == ST_FETCH);
  assign bus.fetch_beat    = fb_q;
  assign bus.res_valid     = res_valid;
  assign bus.res_beat      = rb_q;
  assign bus.res_last      = res_valid && (rb_q == RES_LAST);
  assign bus.res_tag       = tag_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed bench for tensor_core_scheduler; builds with or without TC_SCHED_TIMEOUT_EN.
module tb_tensor_core_scheduler;
`ifdef TC_SCHED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [3:0] tags [4];

  tensor_core_scheduler_if #(
    .NUM_REQ(4), .TAG_WIDTH(4), .FETCH_BEATS(8), .RESULT_BEATS(8)
  ) bus ();

  tensor_core_scheduler #(
    .NUM_REQ(4), .TAG_WIDTH(4), .FETCH_BEATS(8), .RESULT_BEATS(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},    32'(bus.busy), 0);
    check({pfx, "_start"},   32'(bus.tc_start), 0);
    check({pfx, "_rd_en"},   32'(bus.fetch_rd_en), 0);
    check({pfx, "_fdone"},   32'(bus.tc_fetch_done), 0);
    check({pfx, "_valid"},   32'(bus.res_valid), 0);
    check({pfx, "_last"},    32'(bus.res_last), 0);
    check({pfx, "_tag"},     32'(bus.res_tag), 0);
    check({pfx, "_fbeat"},   32'(bus.fetch_beat), 0);
    check({pfx, "_rbeat"},   32'(bus.res_beat), 0);
    check({pfx, "_ready"},   32'(bus.req_ready), 0);
    check({pfx, "_err"},     32'(bus.err_timeout), 0);
  endtask

  task automatic pulse_reset();
    step(); rst = 1'b1; bus.req_valid = '0; #1;
    step(); rst = 1'b0; #1;
  endtask

  task automatic grant(input logic [3:0] reqs, input logic [3:0] exp);
    step();
    bus.req_valid = reqs;
    bus.tc_idle   = 1'b1;
    #1;
    check("idle_busy", 32'(bus.busy), 0);
    check("grant", 32'(bus.req_ready), 32'(exp));
  endtask

  // Drives the core side of one job starting the cycle after a grant.
  task automatic run_job(input logic [3:0] tag, input bit fetch_toggle, input bit wb_gap,
                         input bit stop_after_done, input logic [3:0] req_after);
    int cnt;
    int cyc;
    int beat;
    bit wb;
    step(); bus.req_valid = req_after; bus.tc_idle = 1'b0; #1;
    check("start", 32'(bus.tc_start), 1);
    check("start_tag", 32'(bus.res_tag), 32'(tag));
    check("start_rd_en", 32'(bus.fetch_rd_en), 0);
    cnt = 0;
    cyc = 0;
    while (cnt < 8 && cyc < 40) begin
      step();
      bus.tc_fetch = fetch_toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      check("rd_en", 32'(bus.fetch_rd_en), 1);
      check("fetch_beat", 32'(bus.fetch_beat), 32'(cnt));
      check("fetch_ready", 32'(bus.req_ready), 0);
      if (bus.tc_fetch) cnt++;
      cyc++;
    end
    check("fetch_cycles", 32'(cyc), fetch_toggle ? 15 : 8);
    step(); bus.tc_fetch = 1'b0; bus.tc_compute = 1'b1; #1;
    check("fetch_done", 32'(bus.tc_fetch_done), 1);
    check("done_rd_en", 32'(bus.fetch_rd_en), 0);
    if (stop_after_done) return;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      check("comp_valid", 32'(bus.res_valid), 0);
      check("comp_fdone", 32'(bus.tc_fetch_done), 0);
      check("comp_busy", 32'(bus.busy), 1);
    end
    beat = 0;
    for (int k = 0; k < (wb_gap ? 16 : 10); k++) begin
      wb = wb_gap ? !(k == 4 || k == 5) : (k < 8);
      step(); bus.tc_compute = 1'b0; bus.tc_write_back = wb; #1;
      if (wb && beat < 8) begin
        check("res_valid", 32'(bus.res_valid), 1);
        check("res_beat", 32'(bus.res_beat), 32'(beat));
        check("res_last", 32'(bus.res_last), (beat == 7) ? 1 : 0);
        check("res_tag", 32'(bus.res_tag), 32'(tag));
        beat++;
      end else begin
        check("res_idle_valid", 32'(bus.res_valid), 0);
        check("res_idle_last", 32'(bus.res_last), 0);
      end
      check("wb_busy", 32'(bus.busy), 1);
      check("wb_ready", 32'(bus.req_ready), 0);
    end
    check("beats", 32'(beat), 8);
    step(); bus.tc_write_back = 1'b0; #1;
    check("drain_busy", 32'(bus.busy), 1);
    step(); bus.tc_idle = 1'b1; #1;
    check("drain_busy_idle", 32'(bus.busy), 1);
    check("drain_ready", 32'(bus.req_ready), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    tags     = '{4'hA, 4'hB, 4'h5, 4'hD};
    rst      = 1'b1;
    bus.req_valid     = '0;
    bus.req_tag       = {4'hD, 4'h5, 4'hB, 4'hA};
    bus.tc_idle       = 1'b0;
    bus.tc_fetch      = 1'b0;
    bus.tc_compute    = 1'b0;
    bus.tc_write_back = 1'b0;

    // Reset state, with a live request that must not be granted.
    step(); bus.req_valid = 4'b0100; bus.tc_idle = 1'b1; #1;
    check_quiet("rst");
    step(); rst = 1'b0; bus.req_valid = '0; #1;

    // Single job from requester 2.
    grant(4'b0100, 4'b0100);
    run_job(4'h5, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Round robin with all requesters held valid.
    pulse_reset();
    step(); bus.req_valid = 4'hF; bus.tc_idle = 1'b0; #1;
    check("no_grant_core_busy", 32'(bus.req_ready), 0);
    for (int j = 0; j < 5; j++) begin
      grant(4'hF, 4'(1 << (j % 4)));
      run_job(tags[j % 4], 1'b0, 1'b0, 1'b0, 4'hF);
    end

    // Stalled fetch, then write-back with a gap and excess beats.
    grant(4'b0010, 4'b0010);
    run_job(4'hB, 1'b1, 1'b0, 1'b0, 4'b0000);
    grant(4'b1000, 4'b1000);
    run_job(4'hD, 1'b0, 1'b1, 1'b0, 4'b0000);

    // Reset in COMPUTE with the core still writing back.
    grant(4'b0010, 4'b0010);
    run_job(4'hB, 1'b0, 1'b0, 1'b1, 4'b0000);
    step(); #1;
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1; bus.tc_write_back = 1'b1;
    #1;
    check_quiet("midrst");
    step(); #1;
    check("rst_hold_valid", 32'(bus.res_valid), 0);
    step(); rst = 1'b0; bus.tc_write_back = 1'b0; bus.tc_compute = 1'b0; #1;
    grant(4'b1001, 4'b0001);
    run_job(4'hA, 1'b0, 1'b0, 1'b0, 4'b0000);
    grant(4'b0010, 4'b0010);
    run_job(4'hB, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Core stuck in compute.
    grant(4'b0100, 4'b0100);
    run_job(4'h5, 1'b0, 1'b0, 1'b1, 4'b0000);
`ifdef TC_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step(); #1;
      check("wd_wait_err", 32'(bus.err_timeout), 0);
      check("wd_wait_busy", 32'(bus.busy), 1);
    end
    step(); #1;
    check("wd_err", 32'(bus.err_timeout), 1);
    check("wd_idle", 32'(bus.busy), 0);
    check("wd_tag", 32'(bus.res_tag), 5);
    check("wd_last", 32'(bus.res_last), 0);
    bus.tc_compute = 1'b0;
    grant(4'b0001, 4'b0001);
    check("wd_err_cleared", 32'(bus.err_timeout), 0);
    run_job(4'hA, 1'b0, 1'b0, 1'b0, 4'b0000);
`else
    for (int k = 0; k < 40; k++) begin
      step(); #1;
      check("stuck_err", 32'(bus.err_timeout), 0);
      check("stuck_busy", 32'(bus.busy), 1);
    end
    bus.tc_compute = 1'b0;
    pulse_reset();
    grant(4'b0001, 4'b0001);
    run_job(4'hA, 1'b0, 1'b0, 1'b0, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
